// File: rtl/fb_loader_pkg.sv
// Shared constants, address type and FSM state encoding for the framebuffer loader.
package fb_loader_pkg;

    localparam int unsigned FB_BYTES      = 4096;
    localparam int unsigned FB_ADDR_WIDTH = 12;

    typedef logic [FB_ADDR_WIDTH-1:0] fb_addr_t;

    // Byte index of the last framebuffer location; its write completes a frame.
    localparam fb_addr_t FB_LAST_ADDR = fb_addr_t'(FB_BYTES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        LOAD = 1'b1
    } fb_state_t;

endpackage

// File: rtl/fb_loader_timer.sv
// Inter-byte gap counter for the framebuffer loader.
// Counts enabled cycles since the last clear; expired is asserted combinationally
// in the cycle whose clock edge would complete TIMEOUT_CYCLES idle cycles.
// A clear in the same cycle suppresses expiry, so an arriving byte always wins.
module fb_loader_timer #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd53200
) (
    input  logic clk_in,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    // Expiry detect and next count: clear dominates, counter stops once expired.
    always_comb begin
        expired = enable && !clear && (cnt_q == (TIMEOUT_CYCLES - 16'd1));
        cnt_d   = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && !expired) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Gap counter register.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fb_loader.sv
// UART-to-framebuffer loader: a SYNC_BYTE in IDLE starts a load of FB_BYTES
// pixel bytes, each written to framebuffer port A one cycle after its strobe.
// Optional inter-byte timeout enabled by macro FB_LOADER_TIMEOUT_EN.
module fb_loader
    import fb_loader_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE      = 8'h4C,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd53200
) (
    input  logic                     clk_in,
    input  logic                     reset,
    input  logic [7:0]               rx_data,
    input  logic                     rx_valid,
    output logic [FB_ADDR_WIDTH-1:0] ram_addr,
    output logic [7:0]               ram_data,
    output logic                     ram_we,
    output logic                     ram_clk_en,
    output logic                     busy,
    output logic                     frame_done,
    output logic                     error
);

    fb_state_t state_q, state_d;
    fb_addr_t  idx_q, idx_d;
    fb_addr_t  ram_addr_q, ram_addr_d;
    logic [7:0] ram_data_q, ram_data_d;
    logic      ram_we_q, ram_we_d;
    logic      frame_done_q, frame_done_d;
    logic      error_q, error_d;
    logic      timer_expired;

`ifdef FB_LOADER_TIMEOUT_EN
    logic timer_clear;
    logic timer_enable;

    assign timer_enable = (state_q == LOAD);
    assign timer_clear  = rx_valid || (state_q != LOAD);

    fb_loader_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk_in (clk_in),
        .reset  (reset),
        .clear  (timer_clear),
        .enable (timer_enable),
        .expired(timer_expired)
    );
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timer_expired      = 1'b0;
`endif

    // Next-state and registered-output logic; a byte in LOAD takes priority over expiry.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        ram_addr_d   = ram_addr_q;
        ram_data_d   = ram_data_q;
        ram_we_d     = 1'b0;
        frame_done_d = 1'b0;
        error_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (rx_valid && (rx_data == SYNC_BYTE)) begin
                    state_d = LOAD;
                    idx_d   = '0;
                end
            end
            LOAD: begin
                if (rx_valid) begin
                    ram_we_d   = 1'b1;
                    ram_addr_d = idx_q;
                    ram_data_d = rx_data;
                    // Index wraps to 0 naturally after the last address.
                    idx_d      = idx_q + fb_addr_t'(1);
                    if (idx_q == FB_LAST_ADDR) begin
                        frame_done_d = 1'b1;
                        state_d      = IDLE;
                    end
                end else if (timer_expired) begin
                    error_d = 1'b1;
                    state_d = IDLE;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // State, index and output registers with asynchronous clear.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            ram_addr_q   <= '0;
            ram_data_q   <= '0;
            ram_we_q     <= 1'b0;
            frame_done_q <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            ram_addr_q   <= ram_addr_d;
            ram_data_q   <= ram_data_d;
            ram_we_q     <= ram_we_d;
            frame_done_q <= frame_done_d;
            error_q      <= error_d;
        end
    end

    assign ram_addr   = ram_addr_q;
    assign ram_data   = ram_data_q;
    assign ram_we     = ram_we_q;
    assign ram_clk_en = ram_we_q;
    // State leaves LOAD on the same edge that registers the final write.
    assign busy       = (state_q == LOAD);
    assign frame_done = frame_done_q;
    assign error      = error_q;

endmodule
